// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------
// Two requesters share one system-bus memory port: the instruction-fetch
// read port (if_*) and the execute-stage load/store port (ex_*). Only one
// bus transaction runs at a time. The winning request is latched at grant.
// The FSM waits for bus_ack_i, then returns the read data with a one-cycle
// ready pulse to whichever requester owned the transaction.
//
// Handshake semantics:
//   Each requester raises its request and holds it until it sees its
//   ready_o pulse. The arbiter samples requests only in IDLE. A request
//   withdrawn after grant still completes and still receives its pulse.
//   rdata_o is valid only while ready_o=1 and is 0 otherwise. bus_req_o
//   stays high, with every bus_* output stable, until bus_ack_i is sampled
//   high. bus_ack_i is ignored whenever bus_req_o=0.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   if_re_i/if_addr_i          fetch request and address
//   if_rdata_o/if_ready_o      fetch read data and completion pulse
//   ex_re_i/ex_we_i            execute load/store request
//   ex_addr_i/ex_wdata_i       execute address and store data
//   ex_byte_sel_i/ex_un_sign_i execute access size and unsigned flag
//   ex_rdata_o/ex_ready_o      execute load data and completion pulse
//   hold_o                     pipeline stall while an execute access is pending
//   bus_*_o                    bus request, direction, address, data, size
//   bus_ack_i/bus_rdata_i      bus completion and read data
//   err_o                      bus-timeout pulse, issued with the ready pulse
//
// Optional feature, macro ARB_TIMEOUT_EN:
//   When defined, a transaction is aborted after TIMEOUT_CYC BUSY cycles
//   without ack. The owner then receives 32'hDEADBEEF and err_o pulses.
//   When undefined, the arbiter waits indefinitely and err_o stays 0.

module mem_bus_arbiter #(
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_re_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        ex_re_i,
    input  logic        ex_we_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [1:0]  ex_byte_sel_i,
    input  logic        ex_un_sign_i,
    output logic [31:0] ex_rdata_o,
    output logic        ex_ready_o,
    output logic        hold_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [1:0]  bus_byte_sel_o,
    output logic        bus_un_sign_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    // Fetches are always full-word reads.
    localparam logic [1:0]      SEL_WORD   = 2'b10;

    state_t        state_q;
    logic          owner_q;       // 0 = fetch, 1 = execute
    logic [SW-1:0] starve_q;
    logic          bus_req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    byte_sel_q;
    logic          un_sign_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   ex_rdata_q;
    logic          if_ready_q;
    logic          ex_ready_q;
    logic          err_q;

    logic ex_req;
    logic grant_if;
    logic grant_ex;
    logic tmo_hit;
    logic timeout;

    assign ex_req = ex_re_i | ex_we_i;

    // Execute has priority. Fetch wins once it has lost STARVE_MAX contested rounds.
    always_comb begin
        grant_if = 1'b0;
        grant_ex = 1'b0;
        if (ex_req && if_re_i) begin
            if (starve_q == STARVE_LIM) grant_if = 1'b1;
            else                        grant_ex = 1'b1;
        end else if (ex_req) begin
            grant_ex = 1'b1;
        end else if (if_re_i) begin
            grant_if = 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_q;

    // tmo_q counts completed BUSY cycles. It hits on the TIMEOUT_CYC-th cycle.
    assign tmo_hit = (state_q == BUSY) && (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst || state_q != BUSY || bus_ack_i || tmo_hit) tmo_q <= '0;
        else                                                tmo_q <= tmo_q + 1'b1;
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo_hit        = 1'b0;
`endif

    // A real ack in the same cycle takes precedence over the abort.
    assign timeout = tmo_hit & ~bus_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            starve_q   <= '0;
            bus_req_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byte_sel_q <= '0;
            un_sign_q  <= 1'b0;
            if_rdata_q <= '0;
            ex_rdata_q <= '0;
            if_ready_q <= 1'b0;
            ex_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Responses are single-cycle pulses. Data is zero outside the pulse.
            if_ready_q <= 1'b0;
            ex_ready_q <= 1'b0;
            if_rdata_q <= '0;
            ex_rdata_q <= '0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_ex) begin
                        state_q    <= BUSY;
                        bus_req_q  <= 1'b1;
                        owner_q    <= 1'b1;
                        addr_q     <= ex_addr_i;
                        we_q       <= ex_we_i;  // re+we together is a write
                        wdata_q    <= ex_we_i ? ex_wdata_i : 32'h0;
                        byte_sel_q <= ex_byte_sel_i;
                        un_sign_q  <= ex_un_sign_i;
                        if (if_re_i && starve_q != STARVE_LIM)
                            starve_q <= starve_q + 1'b1;
                    end else if (grant_if) begin
                        state_q    <= BUSY;
                        bus_req_q  <= 1'b1;
                        owner_q    <= 1'b0;
                        addr_q     <= if_addr_i;
                        we_q       <= 1'b0;
                        wdata_q    <= '0;
                        byte_sel_q <= SEL_WORD;
                        un_sign_q  <= 1'b0;
                        starve_q   <= '0;
                    end
                end
                BUSY: begin
                    if (bus_ack_i || timeout) begin
                        state_q    <= RESP;
                        bus_req_q  <= 1'b0;
                        we_q       <= 1'b0;
                        addr_q     <= '0;
                        wdata_q    <= '0;
                        byte_sel_q <= '0;
                        un_sign_q  <= 1'b0;
                        err_q      <= timeout;
                        if (owner_q) begin
                            ex_ready_q <= 1'b1;
                            ex_rdata_q <= timeout ? 32'hDEADBEEF :
                                          (we_q ? 32'h0 : bus_rdata_i);
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= timeout ? 32'hDEADBEEF : bus_rdata_i;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o     = if_rdata_q;
    assign if_ready_o     = if_ready_q;
    assign ex_rdata_o     = ex_rdata_q;
    assign ex_ready_o     = ex_ready_q;
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = we_q;
    assign bus_addr_o     = addr_q;
    assign bus_wdata_o    = wdata_q;
    assign bus_byte_sel_o = byte_sel_q;
    assign bus_un_sign_o  = un_sign_q;
    assign err_o          = err_q;
    assign hold_o         = ex_req & ~ex_ready_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter.
// Inputs are driven, and outputs sampled, on the falling clock edge.
// A negedge monitor pairs every ready pulse with the next entry of exp_q.
// Each entry is {owner, rdata}, where owner 1 = execute.

module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_re_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        ex_re_i;
    logic        ex_we_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic [1:0]  ex_byte_sel_i;
    logic        ex_un_sign_i;
    logic [31:0] ex_rdata_o;
    logic        ex_ready_o;
    logic        hold_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [1:0]  bus_byte_sel_o;
    logic        bus_un_sign_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] exp_q[$];
    bit exp_owner [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    mem_bus_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_re_i       (if_re_i),
        .if_addr_i     (if_addr_i),
        .if_rdata_o    (if_rdata_o),
        .if_ready_o    (if_ready_o),
        .ex_re_i       (ex_re_i),
        .ex_we_i       (ex_we_i),
        .ex_addr_i     (ex_addr_i),
        .ex_wdata_i    (ex_wdata_i),
        .ex_byte_sel_i (ex_byte_sel_i),
        .ex_un_sign_i  (ex_un_sign_i),
        .ex_rdata_o    (ex_rdata_o),
        .ex_ready_o    (ex_ready_o),
        .hold_o        (hold_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_byte_sel_o(bus_byte_sel_o),
        .bus_un_sign_o (bus_un_sign_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i),
        .err_o         (err_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        if_re_i       = 1'b0;
        if_addr_i     = '0;
        ex_re_i       = 1'b0;
        ex_we_i       = 1'b0;
        ex_addr_i     = '0;
        ex_wdata_i    = '0;
        ex_byte_sel_i = '0;
        ex_un_sign_i  = 1'b0;
        bus_ack_i     = 1'b0;
        bus_rdata_i   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus_req_o && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, bus_req_o, 1);
    endtask

    // Ack for one cycle from the current negedge; returns on the RESP negedge.
    task automatic ack_once(input logic [31:0] d);
        bus_ack_i   = 1'b1;
        bus_rdata_i = d;
        tick();
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && (if_ready_o || ex_ready_o)) begin
            if (exp_q.size() == 0)
                check_eq("sb_unexpected_ready", {if_ready_o, ex_ready_o}, 0);
            else
                check_eq("sb_ready", {ex_ready_o, ex_ready_o ? ex_rdata_o : if_rdata_o},
                         exp_q.pop_front());
            check_eq("sb_one_owner", if_ready_o & ex_ready_o, 0);
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        do_reset();
        check_eq("rst_ctrl", {bus_req_o, bus_we_o, if_ready_o, ex_ready_o, hold_o, err_o,
                              bus_un_sign_o, bus_byte_sel_o}, 0);
        check_eq("rst_bus_data", {bus_addr_o, bus_wdata_o}, 0);
        check_eq("rst_rdata", {if_rdata_o, ex_rdata_o}, 0);

        // Fetch-only read, ack two cycles after bus_req_o rises.
        if_re_i   = 1'b1;
        if_addr_i = 32'h100;
        tick();
        check_eq("f_req", {bus_req_o, bus_we_o, hold_o}, 3'b100);
        check_eq("f_addr", bus_addr_o, 32'h100);
        check_eq("f_wdata", bus_wdata_o, 0);
        tick();
        check_eq("f_busy2", {bus_req_o, bus_we_o, bus_addr_o}, {2'b10, 32'h100});
        tick();
        check_eq("f_busy3", {bus_req_o, bus_we_o, bus_addr_o}, {2'b10, 32'h100});
        exp_q.push_back({1'b0, 32'h13});
        ack_once(32'h13);
        check_eq("f_ready", {if_ready_o, ex_ready_o, bus_req_o}, 3'b100);
        check_eq("f_bus_idle", bus_addr_o, 0);
        if_re_i = 1'b0;
        tick();
        check_eq("f_ready_drop", {if_ready_o, if_rdata_o}, 0);

        // Store, ack in the first BUSY cycle.
        ex_we_i       = 1'b1;
        ex_addr_i     = 32'h2000;
        ex_wdata_i    = 32'hA5A5A5A5;
        ex_byte_sel_i = 2'b10;
        #1;
        check_eq("s_hold_req", hold_o, 1);
        tick();
        check_eq("s_ctrl", {bus_req_o, bus_we_o, hold_o, ex_ready_o}, 4'b1110);
        check_eq("s_addr", bus_addr_o, 32'h2000);
        check_eq("s_wdata", bus_wdata_o, 32'hA5A5A5A5);
        check_eq("s_bsel", bus_byte_sel_o, 2'b10);
        exp_q.push_back({1'b1, 32'h0});
        ack_once(32'hFFFFFFFF);
        check_eq("s_ready", {ex_ready_o, hold_o, bus_req_o, bus_we_o}, 4'b1000);
        check_eq("s_wdata_idle", bus_wdata_o, 0);
        ex_we_i = 1'b0;
        tick();
        check_eq("s_ready_drop", {ex_ready_o, ex_rdata_o, hold_o}, 0);

        // Fetch and execute both held: EX,EX,EX,EX,IF,EX.
        do_reset();
        if_re_i   = 1'b1;
        if_addr_i = 32'h1000;
        ex_re_i   = 1'b1;
        ex_addr_i = 32'h2000;
        for (int k = 0; k < 6; k++) begin
            wait_req("arb_req");
            check_eq("arb_grant", bus_addr_o, exp_owner[k] ? 32'h2000 : 32'h1000);
            check_eq("arb_hold_we", {hold_o, bus_we_o}, 2'b10);
            exp_q.push_back({exp_owner[k], 32'h100 + 32'(k)});
            ack_once(32'h100 + 32'(k));
        end
        if_re_i = 1'b0;
        ex_re_i = 1'b0;
        tick();
        tick();
        check_eq("arb_quiet", bus_req_o, 0);

        // Reset in the second BUSY cycle of a load; a late ack is ignored.
        ex_re_i   = 1'b1;
        ex_addr_i = 32'h3000;
        tick();
        check_eq("r_busy1", bus_req_o, 1);
        tick();
        rst     = 1'b1;
        ex_re_i = 1'b0;
        tick();
        check_eq("r_req_drop", {bus_req_o, bus_addr_o}, 0);
        rst         = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h1234;
        tick();
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        check_eq("r_no_ready", {ex_ready_o, if_ready_o, bus_req_o, ex_rdata_o}, 0);
        tick();
        check_eq("r_no_ready2", {ex_ready_o, if_ready_o}, 0);

        // Fetch withdrawn during BUSY still completes.
        if_re_i   = 1'b1;
        if_addr_i = 32'h400;
        tick();
        check_eq("w_busy1", bus_req_o, 1);
        if_re_i = 1'b0;
        tick();
        check_eq("w_busy2", {bus_req_o, bus_addr_o}, {1'b1, 32'h400});
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        ack_once(32'hCAFEF00D);
        check_eq("w_ready", if_ready_o, 1);
        tick();
        check_eq("w_ready_drop", if_ready_o, 0);
        tick();
        check_eq("w_no_regrant", bus_req_o, 0);

        // Load with no ack.
        ex_re_i   = 1'b1;
        ex_addr_i = 32'h5000;
`ifdef ARB_TIMEOUT_EN
        begin
            int n = 0;
            exp_q.push_back({1'b1, 32'hDEADBEEF});
            tick();
            while (bus_req_o && n < 40) begin
                n++;
                tick();
            end
            check_eq("t_busy_cycles", n, 8);
            check_eq("t_ready_err", {ex_ready_o, err_o}, 2'b11);
            ex_re_i = 1'b0;
            tick();
            check_eq("t_err_drop", {err_o, ex_ready_o}, 0);
        end
`else
        tick();
        repeat (20) tick();
        check_eq("t_still_busy", {bus_req_o, err_o, ex_ready_o}, 3'b100);
        exp_q.push_back({1'b1, 32'h77});
        ack_once(32'h77);
        check_eq("t_late_ack", {ex_ready_o, err_o}, 2'b10);
        ex_re_i = 1'b0;
        tick();
`endif

        tick();
        tick();
        check_eq("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single system-bus memory port between two requesters: the instruction-fetch read port and the execute-stage load/store port (mem_re/mem_we/addr/wdata/byte_sel/un_sign).
- Runs one bus transaction at a time. Latches the request at grant, waits for the bus acknowledge, and returns read data with a one-cycle ready pulse.
- Drives hold_o so the pipeline stalls while an execute-stage memory access is outstanding.

Parameters:
STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins over execute
TIMEOUT_CYC, 255, bus cycles without ack before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
if_re_i  input  1  fetch read request, held until if_ready_o
if_addr_i  input  32  fetch address
if_rdata_o  output  32  fetch read data, valid while if_ready_o=1
if_ready_o  output  1  one-cycle fetch completion pulse
ex_re_i  input  1  execute load request
ex_we_i  input  1  execute store request
ex_addr_i  input  32  load/store address
ex_wdata_i  input  32  store data
ex_byte_sel_i  input  2  byte/halfword/word select
ex_un_sign_i  input  1  unsigned-load flag
ex_rdata_o  output  32  load data, valid while ex_ready_o=1
ex_ready_o  output  1  one-cycle execute completion pulse
hold_o  output  1  pipeline stall request
bus_req_o  output  1  bus transaction request
bus_we_o  output  1  1=write, 0=read
bus_addr_o  output  32  bus address
bus_wdata_o  output  32  bus write data
bus_byte_sel_o  output  2  bus byte select
bus_un_sign_o  output  1  bus unsigned flag
bus_ack_i  input  1  bus completion, sampled only while bus_req_o=1
bus_rdata_i  input  32  bus read data, valid with bus_ack_i
err_o  output  1  one-cycle bus-timeout pulse

Behaviour:
- Reset: all outputs 0, state IDLE, starve counter 0, owner register 0.
- Reset mid-transaction: bus_req_o drops on the next edge and no ready pulse is issued. An ack that arrives in IDLE is ignored.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - ex_req = ex_re_i|ex_we_i.
  - If ex_req and if_re_i are both set: grant execute, unless starve counter == STARVE_MAX, in which case grant fetch.
  - If only one requester is active, grant it.
  - On grant: latch the address, we, wdata, byte_sel, un_sign and owner into registers; assert bus_req_o from the next cycle; go to BUSY.
  - ex_re_i and ex_we_i both set: treated as a write.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when execute wins while if_re_i=1.
  - Clears on any fetch grant.
- BUSY:
  - bus_req_o and all bus_* outputs are held stable.
  - On bus_ack_i=1: capture bus_rdata_i into the owner's rdata register (writes capture 0), drop bus_req_o, go to RESP.
  - An ack can arrive in the first BUSY cycle.
- RESP:
  - Owner's ready_o=1 for exactly one cycle, then return to IDLE.
  - The owner's request is ignored in RESP. The requester drops or changes its request after seeing ready.
- Latency: request seen in IDLE at cycle N → bus_req_o at N+1 → ack at M≥N+1 → ready_o at M+1 → next grant decided at M+2, with bus_req_o at M+3.
- Request withdrawn while BUSY: the transaction completes and the ready pulse is still issued.
- Outputs outside their valid windows:
  - rdata_o = 0 when ready_o = 0.
  - bus_wdata_o = 0 for reads.
  - bus_* = 0 when bus_req_o = 0.
- hold_o = ex_req & ~ex_ready_o (combinational). It also stays high while fetch owns the bus and execute waits.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in BUSY.
  - After TIMEOUT_CYC cycles without ack: drop bus_req_o, go to RESP, and return rdata = 32'hDEADBEEF to the owner with its ready pulse.
  - err_o pulses in the same cycle as that ready pulse.
  - The counter clears on leaving BUSY.
- Undefined: the arbiter waits indefinitely for ack, and err_o is tied 0.

Test Plan:
- Fetch-only read, addr 0x100, ack 2 cycles after bus_req_o, rdata 0x00000013 → if_ready_o pulses once with if_rdata_o=0x00000013, and bus_we_o=0 throughout.
- Store ex_we_i, addr 0x2000, wdata 0xA5A5A5A5, byte_sel word, ack in the first BUSY cycle → bus_we_o=1 with stable addr/data, hold_o=1 until the ex_ready_o cycle, and ex_ready_o pulses at ack+1.
- Fetch and execute held continuously, each ack immediate → grant order EX,EX,EX,EX,IF,EX… (fetch wins after 4 lost arbitrations).
- rst=1 in the second BUSY cycle of a load → bus_req_o=0 next cycle, no ready pulse, and an ack one cycle later is ignored.
- Fetch read withdrawn (if_re_i=0) while BUSY → the transaction completes and if_ready_o still pulses once.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no ack → bus_req_o drops after 8 BUSY cycles, then ex_ready_o=1, err_o=1, ex_rdata_o=0xDEADBEEF; without the macro, bus_req_o stays high and err_o stays 0.
